// File: rtl/alu_conv_arb.sv
// Round-robin arbiter sharing one alu_conv datapath between two requesters.
// A tag pipeline routes each result back to its issuer; a flush FSM drains it.
module alu_conv_arb #(
    parameter int LAT = 2,
    parameter int W   = 16,
    parameter int YW  = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    output logic          req1_ready,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [YW-1:0] alu_y,
    output logic          rsp0_valid,
    output logic [YW-1:0] rsp0_y,
    output logic          rsp1_valid,
    output logic [YW-1:0] rsp1_y,
    input  logic          flush,
    output logic          flush_done,
    output logic          busy
);

    localparam int CW = $clog2(LAT + 2);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [LAT:0]    tag_v_q;
    logic [LAT:0]    tag_id_q;
    logic [W-1:0]    alu_a_q, alu_b_q;
    logic            rsp0_valid_q, rsp1_valid_q;
    logic [YW-1:0]   rsp0_y_q, rsp1_y_q;
    logic            flush_done_q, busy_q;

    logic            issue_en_s, issue_s, win_s, exit_s, exit_id_s;

    assign exit_s    = tag_v_q[LAT];
    assign exit_id_s = tag_id_q[LAT];

    // Grant selection: the pointer only breaks ties between two valid requesters.
    always_comb begin
        issue_en_s = (state_q == RUN) && !flush && !reset;
        if (req0_valid && req1_valid) begin
            win_s = ptr_q;
        end else if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        issue_s    = issue_en_s && (req0_valid || req1_valid);
        req0_ready = issue_s && !win_s;
        req1_ready = issue_s && win_s;
    end

    // In-flight count after this cycle's issue and tag exit.
    always_comb begin
        count_d = count_q;
        case ({issue_s, exit_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Flush FSM; DRAIN looks at the post-exit count so DONE is reached without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush) state_d = DRAIN;
                else       state_d = RUN;
            end
            DRAIN: begin
                if (count_d == '0) state_d = DONE;
                else               state_d = DRAIN;
            end
            DONE: begin
                if (!flush) state_d = RUN;
                else        state_d = DONE;
            end
            default: state_d = RUN;
        endcase
    end

    // State, operand, tag pipeline and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            ptr_q        <= 1'b0;
            count_q      <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_y_q     <= '0;
            rsp1_y_q     <= '0;
            flush_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            tag_v_q      <= {tag_v_q[LAT-1:0], issue_s};
            tag_id_q     <= {tag_id_q[LAT-1:0], win_s};
            flush_done_q <= (state_d == DONE);
            busy_q       <= (count_d != '0);
            rsp0_valid_q <= exit_s && !exit_id_s;
            rsp1_valid_q <= exit_s && exit_id_s;
            if (issue_s) begin
                ptr_q   <= !win_s;
                alu_a_q <= win_s ? req1_a : req0_a;
                alu_b_q <= win_s ? req1_b : req0_b;
            end else begin
                ptr_q   <= ptr_q;
                alu_a_q <= alu_a_q;
                alu_b_q <= alu_b_q;
            end
            if (exit_s && !exit_id_s) rsp0_y_q <= alu_y;
            else                      rsp0_y_q <= rsp0_y_q;
            if (exit_s && exit_id_s)  rsp1_y_q <= alu_y;
            else                      rsp1_y_q <= rsp1_y_q;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_y     = rsp0_y_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_y     = rsp1_y_q;
    assign flush_done = flush_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_conv_arb.sv
// Bench for alu_conv_arb: stub adder datapath, queue-based reference model,
// directed literal checks followed by randomized traffic with flushes and resets.
module tb_alu_conv_arb;

    localparam int LAT = 2;
    localparam int W   = 16;
    localparam int YW  = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  alu_a, alu_b;
    logic [YW-1:0] alu_y;
    logic          rsp0_valid, rsp1_valid;
    logic [YW-1:0] rsp0_y, rsp1_y;
    logic          flush = 1'b0;
    logic          flush_done, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_conv_arb #(.LAT(LAT), .W(W), .YW(YW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y),
        .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y),
        .flush(flush), .flush_done(flush_done), .busy(busy)
    );

    // Stub datapath: zero-extended sum delayed by LAT cycles.
    logic [YW-1:0] stub_q [LAT];
    always @(posedge clk) begin
        stub_q[0] <= {2'b00, alu_a} + {2'b00, alu_b};
        for (int k = 1; k < LAT; k++) stub_q[k] <= stub_q[k-1];
    end
    assign alu_y = stub_q[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit            id;
        logic [YW-1:0] y;
        int            due;
    } op_t;

    op_t           q[$];
    bit            model_ok = 1'b0;
    int            cyc = 0;
    int            m_mode = 0;        // 0 run, 1 draining, 2 drained
    bit            m_ptr = 1'b0;
    logic [W-1:0]  m_a = '0, m_b = '0;
    bit            m_rv0 = 1'b0, m_rv1 = 1'b0;
    logic [YW-1:0] m_ry0 = '0, m_ry1 = '0;
    bit            m_fd = 1'b0, m_busy = 1'b0;

    // Compare outputs of the current cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        bit en, w, iss;
        en  = (m_mode == 0) && !flush && !reset;
        w   = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        iss = en && (req0_valid || req1_valid);
        if (model_ok) begin
            chk("req0_ready", 32'(req0_ready), 32'(iss && !w));
            chk("req1_ready", 32'(req1_ready), 32'(iss && w));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("rsp0_valid", 32'(rsp0_valid), 32'(m_rv0));
            chk("rsp0_y", 32'(rsp0_y), 32'(m_ry0));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(m_rv1));
            chk("rsp1_y", 32'(rsp1_y), 32'(m_ry1));
            chk("flush_done", 32'(flush_done), 32'(m_fd));
            chk("busy", 32'(busy), 32'(m_busy));
        end
        if (reset) begin
            q.delete();
            model_ok = 1'b1;
            m_mode = 0; m_ptr = 1'b0; m_a = '0; m_b = '0;
            m_rv0 = 1'b0; m_rv1 = 1'b0; m_ry0 = '0; m_ry1 = '0;
            m_fd = 1'b0; m_busy = 1'b0;
        end else begin
            m_rv0 = 1'b0; m_rv1 = 1'b0;
            if (q.size() > 0 && q[0].due == cyc + 1) begin
                op_t o;
                o = q.pop_front();
                if (o.id) begin m_rv1 = 1'b1; m_ry1 = o.y; end
                else      begin m_rv0 = 1'b1; m_ry0 = o.y; end
            end
            if (iss) begin
                op_t n;
                m_a   = w ? req1_a : req0_a;
                m_b   = w ? req1_b : req0_b;
                n.id  = w;
                n.y   = {2'b00, m_a} + {2'b00, m_b};
                n.due = cyc + LAT + 2;
                q.push_back(n);
                m_ptr = !w;
            end
            if (m_mode == 0 && flush)              m_mode = 1;
            else if (m_mode == 1 && q.size() == 0) m_mode = 2;
            else if (m_mode == 2 && !flush)        m_mode = 0;
            m_fd   = (m_mode == 2);
            m_busy = (q.size() != 0);
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
    endtask

    initial begin
        int fl_cnt;
        fl_cnt = 0;
        // 1: reset then idle
        step(); step();
        reset = 1'b0;
        step(); step();
        chk("idle_ready0", 32'(req0_ready), 32'd0);
        chk("idle_ready1", 32'(req1_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rsp0", 32'(rsp0_valid), 32'd0);

        // 2: single req0 operation
        set_req(1'b1, 16'h0002, 16'h0003, 1'b0, 16'h0000, 16'h0000);
        #1 chk("t2_grant", 32'(req0_ready), 32'd1);
        step();
        set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        chk("t2_alu_a", 32'(alu_a), 32'h2);
        chk("t2_alu_b", 32'(alu_b), 32'h3);
        step(); step();
        chk("t2_early", 32'(rsp0_valid), 32'd0);
        step();
        chk("t2_rsp_v", 32'(rsp0_valid), 32'd1);
        chk("t2_rsp_y", 32'(rsp0_y), 32'h00005);
        chk("t2_rsp1", 32'(rsp1_valid), 32'd0);
        step();
        chk("t2_pulse", 32'(rsp0_valid), 32'd0);

        // 3: alternating grants from a fresh pointer
        reset = 1'b1; step(); step(); reset = 1'b0;
        set_req(1'b1, 16'h0004, 16'h0005, 1'b1, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_grant0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("t3_grant1", 32'(req1_ready), 32'(i % 2 == 1));
            step();
        end
        set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                chk("t3_rsp0_v", 32'(rsp0_valid), 32'd1);
                chk("t3_rsp0_y", 32'(rsp0_y), 32'h00009);
            end else begin
                chk("t3_rsp1_v", 32'(rsp1_valid), 32'd1);
                chk("t3_rsp1_y", 32'(rsp1_y), 32'h1FFFE);
            end
            step();
        end

        // 4: back-to-back issues then flush
        set_req(1'b1, 16'h0010, 16'h0001, 1'b0, 16'h0000, 16'h0000);
        step(); step(); step();
        flush = 1'b1;
        #1 chk("t4_ready_low", 32'(req0_ready), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 30 && flush_done !== 1'b1; k++) step();
        chk("t4_drain_bound", 32'(flush_done), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);
        step();
        flush = 1'b0;
        step();
        #1 chk("t4_fd_low", 32'(flush_done), 32'd0);
        chk("t4_resume", 32'(req0_ready), 32'd1);
        step();
        set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        repeat (6) step();

        // 5: reset discards in-flight operations
        set_req(1'b1, 16'h0100, 16'h0200, 1'b1, 16'h0300, 16'h0400);
        step(); step();
        set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
            chk("t5_busy", 32'(busy), 32'd0);
            step();
        end
        set_req(1'b1, 16'h0001, 16'h0001, 1'b1, 16'h0002, 16'h0002);
        #1 chk("t5_ptr0", 32'(req0_ready), 32'd1);
        step();
        set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        repeat (6) step();

        // 6: flush while idle
        set_req(1'b1, 16'h0007, 16'h0007, 1'b1, 16'h0008, 16'h0008);
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t6_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("t6_fd", 32'(flush_done), 32'(i >= 2));
            step();
        end
        flush = 1'b0;
        set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_req($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                    $urandom_range(0, 2) != 0, 16'($urandom), 16'($urandom));
            if (fl_cnt > 0) begin
                flush = 1'b1;
                fl_cnt--;
            end else if ($urandom_range(0, 24) == 0) begin
                flush = 1'b1;
                fl_cnt = $urandom_range(0, 8);
            end else begin
                flush = 1'b0;
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        flush = 1'b0;
        set_req(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
